// File: rtl/mem_stage_if.sv
// Bundle of the EX->M handshake, the data-memory req/ack bus and the registered M/W outputs.
// The slave modport is the memory stage itself; the master modport is its environment (EX, DMEM, WB).
interface mem_stage_if;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_o;
    logic [31:0] x_b;
    logic [31:0] x_insn;
    logic        x_dmwe;
    logic        x_rwd;
    logic        x_rwe;
    logic        x_rdst;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        w_valid;
    logic [31:0] w_o;
    logic [31:0] w_d;
    logic [31:0] w_insn;
    logic        w_rwe;
    logic        w_rwd;
    logic        w_rdst;
    logic        m_err;

    modport slave (
        input  x_valid, x_o, x_b, x_insn, x_dmwe, x_rwd, x_rwe, x_rdst,
        output x_ready,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ack, dm_rdata,
        output w_valid, w_o, w_d, w_insn, w_rwe, w_rwd, w_rdst, m_err
    );

    modport master (
        output x_valid, x_o, x_b, x_insn, x_dmwe, x_rwd, x_rwe, x_rdst,
        input  x_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ack, dm_rdata,
        input  w_valid, w_o, w_d, w_insn, w_rwe, w_rwd, w_rdst, m_err
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: runs loads/stores against DMEM over req/ack, stalls EX while busy,
// formats big-endian load data and registers the M/W bundle for writeback.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tcnt;

    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;

    logic        w_valid, w_rwe, w_rwd, w_rdst, m_err;
    logic [31:0] w_o, w_d, w_insn;

    logic        lat_load, lat_rwe, lat_signed;
    size_t       lat_size;
    logic [1:0]  lat_off;

    logic        accept, is_load, is_store, is_mem, misaligned, dec_signed;
    logic [5:0]  opcode;
    size_t       dec_size;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_fmt;

    assign bus.x_ready = (state == IDLE) && !rst;
    assign accept      = bus.x_valid && bus.x_ready;

    // Decode access size, alignment and the store lane layout of the incoming bundle.
    always_comb begin
        opcode     = bus.x_insn[31:26];
        is_store   = bus.x_dmwe;
        is_load    = bus.x_rwd && !bus.x_dmwe;
        is_mem     = is_store || is_load;
        dec_size   = SZ_W;
        dec_signed = 1'b0;
        if (is_store) begin
            case (opcode)
                6'h28:   dec_size = SZ_B;
                6'h29:   dec_size = SZ_H;
                default: dec_size = SZ_W;
            endcase
        end else if (is_load) begin
            case (opcode)
                6'h20:   begin dec_size = SZ_B; dec_signed = 1'b1; end
                6'h21:   begin dec_size = SZ_H; dec_signed = 1'b1; end
                6'h24:   dec_size = SZ_B;
                6'h25:   dec_size = SZ_H;
                default: dec_size = SZ_W;
            endcase
        end
        misaligned = ((dec_size == SZ_H) && bus.x_o[0]) ||
                     ((dec_size == SZ_W) && (bus.x_o[1:0] != 2'b00));
        case (dec_size)
            SZ_B:    dec_be = 4'b1000 >> bus.x_o[1:0];
            SZ_H:    dec_be = bus.x_o[1] ? 4'b0011 : 4'b1100;
            default: dec_be = 4'b1111;
        endcase
        dec_wdata = 32'h0;
        if (is_store) begin
            case (dec_size)
                SZ_B:    dec_wdata = {4{bus.x_b[7:0]}};
                SZ_H:    dec_wdata = {2{bus.x_b[15:0]}};
                default: dec_wdata = bus.x_b;
            endcase
        end
    end

    // Byte offset 0 is the most significant lane (big-endian).
    always_comb begin
        case (lat_off)
            2'd0:    lane_b = bus.dm_rdata[31:24];
            2'd1:    lane_b = bus.dm_rdata[23:16];
            2'd2:    lane_b = bus.dm_rdata[15:8];
            default: lane_b = bus.dm_rdata[7:0];
        endcase
        lane_h = lat_off[1] ? bus.dm_rdata[15:0] : bus.dm_rdata[31:16];
        case (lat_size)
            SZ_B:    load_fmt = lat_signed ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            SZ_H:    load_fmt = lat_signed ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
            default: load_fmt = bus.dm_rdata;
        endcase
    end

    // Stage FSM; w_valid, w_rwe and m_err default to 0 so they pulse for one cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= 8'h0;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= 32'h0;
            dm_wdata   <= 32'h0;
            dm_be      <= 4'h0;
            w_valid    <= 1'b0;
            w_o        <= 32'h0;
            w_d        <= 32'h0;
            w_insn     <= 32'h0;
            w_rwe      <= 1'b0;
            w_rwd      <= 1'b0;
            w_rdst     <= 1'b0;
            m_err      <= 1'b0;
            lat_load   <= 1'b0;
            lat_rwe    <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_W;
            lat_off    <= 2'b00;
        end else begin
            w_valid <= 1'b0;
            w_rwe   <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        w_o    <= bus.x_o;
                        w_insn <= bus.x_insn;
                        w_rwd  <= bus.x_rwd;
                        w_rdst <= bus.x_rdst;
                        w_d    <= 32'h0;
                        if (!is_mem) begin
                            w_valid <= 1'b1;
                            w_rwe   <= bus.x_rwe;
                        end else if (misaligned) begin
                            w_valid <= 1'b1;
                            m_err   <= 1'b1;
                        end else begin
                            state      <= ACCESS;
                            tcnt       <= 8'h0;
                            dm_req     <= 1'b1;
                            dm_we      <= is_store;
                            dm_addr    <= {bus.x_o[31:2], 2'b00};
                            dm_wdata   <= dec_wdata;
                            dm_be      <= dec_be;
                            lat_load   <= is_load;
                            lat_rwe    <= bus.x_rwe;
                            lat_signed <= dec_signed;
                            lat_size   <= dec_size;
                            lat_off    <= bus.x_o[1:0];
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving on the timeout edge still completes normally.
                    if (bus.dm_ack) begin
                        state   <= IDLE;
                        dm_req  <= 1'b0;
                        w_valid <= 1'b1;
                        w_rwe   <= lat_rwe;
                        w_d     <= lat_load ? load_fmt : 32'h0;
                    end else if (tcnt == TLAST) begin
                        state   <= IDLE;
                        dm_req  <= 1'b0;
                        w_valid <= 1'b1;
                        m_err   <= 1'b1;
                        w_d     <= 32'h0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dm_req   = dm_req;
    assign bus.dm_we    = dm_we;
    assign bus.dm_addr  = dm_addr;
    assign bus.dm_wdata = dm_wdata;
    assign bus.dm_be    = dm_be;
    assign bus.w_valid  = w_valid;
    assign bus.w_o      = w_o;
    assign bus.w_d      = w_d;
    assign bus.w_insn   = w_insn;
    assign bus.w_rwe    = w_rwe;
    assign bus.w_rwd    = w_rwd;
    assign bus.w_rdst   = w_rdst;
    assign bus.m_err    = m_err;

endmodule
